// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state_q;
  logic [CW-1:0] starveCnt_q, starveCnt_d;
  logic          discard_q;
  logic          memReq_q, memWe_q;
  logic [31:0]   memAddr_q, memWdata_q;
  logic          ifReady_q, dmReady_q;
  logic [31:0]   ifRdata_q, dmRdata_q;
  logic          anyReq, grantFetch;

  // Fetch only wins when data is absent or the fetch has waited out its limit.
  always_comb begin
    anyReq      = if_req | dm_req;
    grantFetch  = if_req && (!dm_req || (starveCnt_q == LIMIT));
    starveCnt_d = starveCnt_q;
    if (state_q == IDLE && anyReq) begin
      if (grantFetch)
        starveCnt_d = '0;
      else if (if_req && starveCnt_q != LIMIT)
        starveCnt_d = starveCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      discard_q   <= 1'b0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= 32'h0;
      memWdata_q  <= 32'h0;
      ifReady_q   <= 1'b0;
      dmReady_q   <= 1'b0;
      ifRdata_q   <= 32'h0;
      dmRdata_q   <= 32'h0;
    end else begin
      ifReady_q   <= 1'b0;
      dmReady_q   <= 1'b0;
      starveCnt_q <= starveCnt_d;
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            memReq_q <= 1'b1;
            if (grantFetch) begin
              state_q    <= FETCH;
              memAddr_q  <= if_addr;
              memWe_q    <= 1'b0;
              memWdata_q <= 32'h0;
              discard_q  <= if_flush;
            end else begin
              state_q    <= DATA;
              memAddr_q  <= dm_addr;
              memWe_q    <= dm_we;
              memWdata_q <= dm_wdata;
            end
          end
        end
        // A flush seen at any point of the fetch suppresses its response.
        FETCH: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            memReq_q  <= 1'b0;
            discard_q <= 1'b0;
            if (!(discard_q || if_flush)) begin
              ifReady_q <= 1'b1;
              ifRdata_q <= mem_rdata;
            end
          end else if (if_flush) begin
            discard_q <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            memReq_q  <= 1'b0;
            dmReady_q <= 1'b1;
            if (!memWe_q)
              dmRdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign if_ready  = ifReady_q;
  assign if_rdata  = ifRdata_q;
  assign dm_ready  = dmReady_q;
  assign dm_rdata  = dmRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; outputs sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  int testsRun = 0;
  int testsFailed = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One rising edge, then settle to the falling edge where outputs are checked.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] expAddr;
  logic        expFetch;

  initial begin
    rst = 1'b1; if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h123;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_readys", {30'b0, if_ready, dm_ready}, 32'h0);
    checkOutput("rst_rdata", if_rdata | dm_rdata, 32'h0);
    rst = 1'b0; dm_req = 1'b0; dm_addr = 0;
    applyStimulus();
    checkOutput("idle_no_req", {31'b0, mem_req}, 32'h0);

    // Single fetch
    if_req = 1'b1; if_addr = 32'h40;
    applyStimulus();
    checkOutput("f_mem_req", {31'b0, mem_req}, 32'h1);
    checkOutput("f_mem_addr", mem_addr, 32'h40);
    checkOutput("f_mem_we", {31'b0, mem_we}, 32'h0);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00500093;
    applyStimulus();
    checkOutput("f_if_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("f_if_rdata", if_rdata, 32'h00500093);
    checkOutput("f_dm_ready", {31'b0, dm_ready}, 32'h0);
    checkOutput("f_req_drop", {31'b0, mem_req}, 32'h0);
    mem_ack = 1'b0;
    applyStimulus();
    checkOutput("f_pulse_end", {31'b0, if_ready}, 32'h0);

    // Simultaneous requests: data first, fetch two cycles after the data ack
    if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    applyStimulus();
    checkOutput("s_data_addr", mem_addr, 32'h100);
    checkOutput("s_data_we", {31'b0, mem_we}, 32'h0);
    dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    applyStimulus();
    checkOutput("s_dm_ready", {30'b0, if_ready, dm_ready}, 32'h1);
    checkOutput("s_dm_rdata", dm_rdata, 32'h12345678);
    checkOutput("s_req_low", {31'b0, mem_req}, 32'h0);
    mem_ack = 1'b0;
    applyStimulus();
    checkOutput("s_fetch_req", {31'b0, mem_req}, 32'h1);
    checkOutput("s_fetch_addr", mem_addr, 32'h44);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
    applyStimulus();
    checkOutput("s_if_ready", {30'b0, if_ready, dm_ready}, 32'h2);
    checkOutput("s_if_rdata", if_rdata, 32'hAAAA5555);
    mem_ack = 1'b0;
    applyStimulus();

    // Starvation: four data grants, one fetch, then data again
    dm_req = 1'b1; dm_addr = 32'h300; if_req = 1'b1; if_addr = 32'h80;
    for (int g = 0; g < 6; g++) begin
      expFetch = (g == 4);
      expAddr  = expFetch ? 32'h80 : 32'h300;
      applyStimulus();
      checkOutput($sformatf("st_addr%0d", g), mem_addr, expAddr);
      checkOutput($sformatf("st_req%0d", g), {31'b0, mem_req}, 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h11110000 + g;
      applyStimulus();
      checkOutput($sformatf("st_ready%0d", g), {30'b0, if_ready, dm_ready},
                  expFetch ? 32'h2 : 32'h1);
      mem_ack = 1'b0;
      if (g == 5) begin
        dm_req = 1'b0; if_req = 1'b0;
      end
    end
    checkOutput("st_if_rdata", if_rdata, 32'h11110004);
    checkOutput("st_dm_rdata", dm_rdata, 32'h11110005);
    applyStimulus();

    // Flush one cycle after grant, ack three cycles after grant
    if_req = 1'b1; if_addr = 32'h90;
    applyStimulus();
    checkOutput("fl_grant", mem_addr, 32'h90);
    if_req = 1'b0; if_flush = 1'b1;
    applyStimulus();
    if_flush = 1'b0;
    applyStimulus();
    checkOutput("fl_hold", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    applyStimulus();
    checkOutput("fl_no_ready", {30'b0, if_ready, dm_ready}, 32'h0);
    checkOutput("fl_rdata_kept", if_rdata, 32'h11110004);
    checkOutput("fl_req_drop", {31'b0, mem_req}, 32'h0);
    mem_ack = 1'b0;
    applyStimulus();
    checkOutput("fl_idle", {31'b0, mem_req}, 32'h0);
    if_req = 1'b1; if_addr = 32'hA0;
    applyStimulus();
    checkOutput("fl_next_addr", mem_addr, 32'hA0);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hC0FFEE00;
    applyStimulus();
    checkOutput("fl_next_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("fl_next_rdata", if_rdata, 32'hC0FFEE00);
    mem_ack = 1'b0;
    applyStimulus();

    // Store, with requester inputs changing while the access is outstanding
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("sw_we", {31'b0, mem_we}, 32'h1);
    checkOutput("sw_addr", mem_addr, 32'h200);
    checkOutput("sw_wdata", mem_wdata, 32'hDEADBEEF);
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h204; dm_wdata = 32'h0BADF00D; if_flush = 1'b1;
    applyStimulus();
    if_flush = 1'b0;
    checkOutput("sw_hold_addr", mem_addr, 32'h200);
    checkOutput("sw_hold_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("sw_hold_we", {31'b0, mem_we}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    applyStimulus();
    checkOutput("sw_ready", {30'b0, if_ready, dm_ready}, 32'h1);
    checkOutput("sw_rdata_kept", dm_rdata, 32'h11110005);
    mem_ack = 1'b0;
    applyStimulus();
    checkOutput("sw_pulse_end", {31'b0, dm_ready}, 32'h0);

    // Reset while waiting for a data ack, then a stray late ack
    dm_req = 1'b1; dm_addr = 32'h300;
    applyStimulus();
    checkOutput("rm_granted", {31'b0, mem_req}, 32'h1);
    dm_req = 1'b0; rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("rm_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rm_addr_wdata", mem_addr | mem_wdata, 32'h0);
    checkOutput("rm_rdata", if_rdata | dm_rdata, 32'h0);
    checkOutput("rm_readys", {29'b0, mem_we, if_ready, dm_ready}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    applyStimulus();
    checkOutput("rm_late_ready", {30'b0, if_ready, dm_ready}, 32'h0);
    checkOutput("rm_late_rdata", dm_rdata, 32'h0);
    mem_ack = 1'b0;
    applyStimulus();
    checkOutput("rm_idle", {31'b0, mem_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data grants issued while a fetch request waits.
REQ-002 The block SHALL have the following ports; clock and reset come first.
- clk  in  1  clock, rising edge; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch stage requests an instruction word.
- if_addr  in  32  fetch address.
- if_flush  in  1  jump taken; discard any in-flight fetch.
- if_ready  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  memory stage requests a load or store.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ready  out  1  one-cycle pulse; access complete.
- dm_rdata  out  32  load data.
- mem_req  out  1  shared memory request, held until mem_ack.
- mem_we  out  1  shared memory write enable.
- mem_addr  out  32  shared memory address.
- mem_wdata  out  32  shared memory write data.
- mem_rdata  in  32  shared memory read data, valid with mem_ack.
- mem_ack  in  1  memory completes the current request.

Function
REQ-003 The block SHALL implement an FSM with the states IDLE, FETCH and DATA.
REQ-004 In IDLE with any request pending, the block SHALL select a grant and, on the next edge, enter FETCH or DATA.
- On that edge it SHALL register the granted address, we and wdata onto mem_addr, mem_we and mem_wdata.
- On that edge it SHALL set mem_req=1.
- For a fetch grant, mem_we SHALL be 0.
REQ-005 Grant priority SHALL be data over fetch, except as overridden by the starvation rule.
- The starvation counter SHALL be 3 bits or wider and SHALL saturate at STARVE_LIMIT.
- It SHALL increment on each data grant made while if_req=1.
- It SHALL clear on each fetch grant.
- When the counter equals STARVE_LIMIT and if_req=1, the next grant SHALL go to fetch.
REQ-006 mem_req, mem_addr, mem_we and mem_wdata SHALL remain stable from the grant until the cycle in which mem_ack=1 is sampled.
- Changes on requester inputs during that window SHALL be ignored.
REQ-007 On the edge where mem_ack=1 is sampled in FETCH or DATA:
- mem_req SHALL drop to 0.
- The FSM SHALL return to IDLE.
- The matching response SHALL be issued on the same edge: if_ready/if_rdata for a fetch, dm_ready/dm_rdata for a data access.
- The ready output SHALL pulse for exactly one cycle.
REQ-008 The latency rules SHALL be as follows:
- Request first seen in IDLE at cycle T gives mem_req=1 at T+1.
- mem_ack sampled at cycle A gives ready=1 at A+1.
- Minimum request-to-ready latency is 2 cycles.
- The next grant is issued at A+2 at the earliest.
REQ-009 dm_rdata SHALL update only on completed loads; stores SHALL pulse dm_ready and leave dm_rdata unchanged.
- if_rdata SHALL update only on completed, unflushed fetches.
REQ-010 if_flush=1 in any cycle from fetch grant through the ack edge SHALL mark the fetch discarded.
- This includes if_flush coincident with the grant edge and with mem_ack.
- On ack of a discarded fetch, if_ready SHALL stay 0 and if_rdata SHALL stay unchanged.
- The FSM SHALL still wait for mem_ack before returning to IDLE.
REQ-011 if_flush SHALL have no effect in IDLE or in DATA.
REQ-012 mem_ack sampled in IDLE SHALL be ignored.
REQ-013 if_ready and dm_ready SHALL never be 1 in the same cycle.
REQ-014 At most one memory request SHALL be outstanding at any time.

Reset
REQ-015 With rst=1 at an edge, the block SHALL set:
- the state to IDLE;
- the starvation counter and the discard flag to 0;
- mem_req, mem_we, if_ready and dm_ready to 0;
- mem_addr, mem_wdata, if_rdata and dm_rdata to 32'h0.
REQ-016 Reset during FETCH or DATA SHALL abandon the transaction without issuing any ready pulse.
- A mem_ack arriving after reset SHALL be ignored per REQ-012.
REQ-017 Requests present while rst=1 SHALL be granted no earlier than the first edge after rst deasserts.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single fetch: if_req=1, if_addr=0x40 at T; memory acks at T+1 with 0x00500093. Expect mem_req=1 and mem_addr=0x40 at T+1, if_ready=1 and if_rdata=0x00500093 at T+2, and dm_ready=0 throughout.
- Simultaneous requests: if_req and dm_req (load 0x100) both at T. Expect data granted first, dm_ready on its ack, then fetch granted 2 cycles after the data ack.
- Starvation, STARVE_LIMIT=4: dm_req held high continuously with if_req=1. Expect exactly 4 data grants, then a fetch grant, then the data grants resume.
- Flush: fetch granted, if_flush=1 one cycle later, ack 3 cycles after grant. Expect no if_ready pulse, if_rdata unchanged, and the FSM back in IDLE after the ack.
- Store: dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF. Expect mem_we=1 with matching addr/wdata until ack, dm_ready pulse, and dm_rdata unchanged.
- Reset mid-transaction: rst=1 while in DATA awaiting ack, then a late mem_ack after rst deasserts. Expect all outputs zero, no ready pulse, and the FSM to stay in IDLE.
